control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_pkg.sv | 108 ++++++++++
 rtl/control_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared CPU definitions: opcode and ALU encodings, sequencer states, control word.
// Also used by the ALU and by testbenches.
`default_nettype none

package control_sequencer_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_t;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  // Instructions grouped by the shape of their execute phase.
  typedef enum logic [2:0] {
    CL_NOP  = 3'd0,
    CL_HALT = 3'd1,
    CL_LD   = 3'd2,
    CL_LDI  = 3'd3,
    CL_ST   = 3'd4,
    CL_ALU  = 3'd5,
    CL_ALUI = 3'd6,
    CL_BR   = 3'd7
  } instr_class_t;

  typedef struct packed {
    logic    gra;
    logic    grb;
    logic    grc;
    logic    rin;
    logic    rout;
    logic    baout;
    logic    pc_out;
    logic    pc_in;
    logic    inc_pc;
    logic    mar_in;
    logic    mdr_in;
    logic    mdr_out;
    logic    read;
    logic    write;
    logic    ir_in;
    logic    y_in;
    logic    z_in;
    logic    zlo_out;
    logic    c_out;
    logic    con_in;
    alu_op_t alu_op;
    logic    run;
  } ctrl_t;

  // Unlisted opcodes fall into CL_NOP so they execute as a no-operation.
  function automatic instr_class_t decode_class(input logic [4:0] op);
    instr_class_t cls;
    case (op)
      OP_LD:                    cls = CL_LD;
      OP_LDI:                   cls = CL_LDI;
      OP_ST:                    cls = CL_ST;
      OP_ADD, OP_SUB,
      OP_AND, OP_OR:            cls = CL_ALU;
      OP_ADDI, OP_ANDI, OP_ORI: cls = CL_ALUI;
      OP_BR:                    cls = CL_BR;
      OP_HALT:                  cls = CL_HALT;
      default:                  cls = CL_NOP;
    endcase
    return cls;
  endfunction

  function automatic alu_op_t alu_select(input logic [4:0] op);
    alu_op_t sel;
    case (op)
      OP_SUB:          sel = ALU_SUB;
      OP_AND, OP_ANDI: sel = ALU_AND;
      OP_OR, OP_ORI:   sel = ALU_OR;
      default:         sel = ALU_ADD;
    endcase
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch T0-T2, opcode-dependent execute T3-T7,
// HALT on halt opcode or stop request at an instruction boundary.
`default_nettype none

module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ir_out,
  input  logic        con_ff,
  input  logic        stop,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        rin,
  output logic        rout,
  output logic        baout,
  output logic        pc_out,
  output logic        pc_in,
  output logic        inc_pc,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        read,
  output logic        write,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        zlo_out,
  output logic        c_out,
  output logic        con_in,
  output logic [1:0]  alu_op,
  output logic        run
);

  state_t       state;
  state_t       state_next;
  state_t       boundary;
  ctrl_t        ctrl;
  logic [4:0]   opcode;
  instr_class_t cls;
  logic         unused_ir_bits;

  assign opcode         = ir_out[31:27];
  assign cls            = decode_class(opcode);
  assign unused_ir_bits = ^ir_out[26:0];

  // Every instruction end funnels through here so stop is honoured uniformly.
  assign boundary = stop ? S_HALT : S_T0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_RST;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    ctrl       = '0;
    state_next = state;
    ctrl.run   = (state != S_RST) && (state != S_HALT);

    case (state)
      S_RST: begin
        state_next = S_T0;
      end

      S_T0: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
        ctrl.inc_pc = 1'b1;
        ctrl.z_in   = 1'b1;
        state_next  = S_T1;
      end

      S_T1: begin
        ctrl.zlo_out = 1'b1;
        ctrl.pc_in   = 1'b1;
        ctrl.read    = 1'b1;
        ctrl.mdr_in  = 1'b1;
        state_next   = S_T2;
      end

      // IR is loaded at the end of T2, so the branch decision looks at the opcode
      // presented on ir_out in this cycle; T0/T1 never look at it.
      S_T2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
        case (cls)
          CL_NOP:  state_next = boundary;
          CL_HALT: state_next = S_HALT;
          default: state_next = S_T3;
        endcase
      end

      S_T3: begin
        state_next = S_T4;
        case (cls)
          CL_ALU, CL_ALUI: begin
            ctrl.grb  = 1'b1;
            ctrl.rout = 1'b1;
            ctrl.y_in = 1'b1;
          end
          CL_LD, CL_LDI, CL_ST: begin
            ctrl.grb   = 1'b1;
            ctrl.baout = 1'b1;
            ctrl.y_in  = 1'b1;
          end
          CL_BR: begin
            ctrl.gra    = 1'b1;
            ctrl.rout   = 1'b1;
            ctrl.con_in = 1'b1;
          end
          default: state_next = boundary;
        endcase
      end

      S_T4: begin
        state_next = S_T5;
        case (cls)
          CL_ALU: begin
            ctrl.grc    = 1'b1;
            ctrl.rout   = 1'b1;
            ctrl.alu_op = alu_select(opcode);
            ctrl.z_in   = 1'b1;
          end
          CL_ALUI: begin
            ctrl.c_out  = 1'b1;
            ctrl.alu_op = alu_select(opcode);
            ctrl.z_in   = 1'b1;
          end
          CL_LD, CL_LDI, CL_ST: begin
            ctrl.c_out = 1'b1;
            ctrl.z_in  = 1'b1;
          end
          CL_BR: begin
            ctrl.pc_out = 1'b1;
            ctrl.y_in   = 1'b1;
          end
          default: state_next = boundary;
        endcase
      end

      S_T5: begin
        case (cls)
          CL_ALU, CL_ALUI, CL_LDI: begin
            ctrl.zlo_out = 1'b1;
            ctrl.gra     = 1'b1;
            ctrl.rin     = 1'b1;
            state_next   = boundary;
          end
          CL_LD, CL_ST: begin
            ctrl.zlo_out = 1'b1;
            ctrl.mar_in  = 1'b1;
            state_next   = S_T6;
          end
          CL_BR: begin
            ctrl.c_out = 1'b1;
            ctrl.z_in  = 1'b1;
            state_next = S_T6;
          end
          default: state_next = boundary;
        endcase
      end

      S_T6: begin
        case (cls)
          CL_LD: begin
            ctrl.read   = 1'b1;
            ctrl.mdr_in = 1'b1;
            state_next  = S_T7;
          end
          CL_ST: begin
            ctrl.gra    = 1'b1;
            ctrl.rout   = 1'b1;
            ctrl.mdr_in = 1'b1;
            state_next  = S_T7;
          end
          CL_BR: begin
            ctrl.zlo_out = 1'b1;
            ctrl.pc_in   = con_ff;
            state_next   = boundary;
          end
          default: state_next = boundary;
        endcase
      end

      S_T7: begin
        state_next = boundary;
        case (cls)
          CL_LD: begin
            ctrl.mdr_out = 1'b1;
            ctrl.gra     = 1'b1;
            ctrl.rin     = 1'b1;
          end
          CL_ST: begin
            ctrl.write = 1'b1;
          end
          default: ;
        endcase
      end

      S_HALT: begin
        state_next = S_HALT;
      end

      default: begin
        state_next = S_RST;
      end
    endcase
  end

  assign gra     = ctrl.gra;
  assign grb     = ctrl.grb;
  assign grc     = ctrl.grc;
  assign rin     = ctrl.rin;
  assign rout    = ctrl.rout;
  assign baout   = ctrl.baout;
  assign pc_out  = ctrl.pc_out;
  assign pc_in   = ctrl.pc_in;
  assign inc_pc  = ctrl.inc_pc;
  assign mar_in  = ctrl.mar_in;
  assign mdr_in  = ctrl.mdr_in;
  assign mdr_out = ctrl.mdr_out;
  assign read    = ctrl.read;
  assign write   = ctrl.write;
  assign ir_in   = ctrl.ir_in;
  assign y_in    = ctrl.y_in;
  assign z_in    = ctrl.z_in;
  assign zlo_out = ctrl.zlo_out;
  assign c_out   = ctrl.c_out;
  assign con_in  = ctrl.con_in;
  assign alu_op  = ctrl.alu_op;
  assign run     = ctrl.run;

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: per-opcode micro-step tables queue expected control words,
// a negedge monitor pops and compares one word per clock.
`default_nettype none

module tb_control_sequencer;

  typedef logic [22:0] word_t;
  typedef struct {
    word_t w;
    string name;
  } exp_t;

  localparam word_t GRA     = 23'd1 << 0;
  localparam word_t GRB     = 23'd1 << 1;
  localparam word_t GRC     = 23'd1 << 2;
  localparam word_t RIN     = 23'd1 << 3;
  localparam word_t ROUT    = 23'd1 << 4;
  localparam word_t BAOUT   = 23'd1 << 5;
  localparam word_t PC_OUT  = 23'd1 << 6;
  localparam word_t PC_IN   = 23'd1 << 7;
  localparam word_t INC_PC  = 23'd1 << 8;
  localparam word_t MAR_IN  = 23'd1 << 9;
  localparam word_t MDR_IN  = 23'd1 << 10;
  localparam word_t MDR_OUT = 23'd1 << 11;
  localparam word_t READ    = 23'd1 << 12;
  localparam word_t WRITE   = 23'd1 << 13;
  localparam word_t IR_IN   = 23'd1 << 14;
  localparam word_t Y_IN    = 23'd1 << 15;
  localparam word_t Z_IN    = 23'd1 << 16;
  localparam word_t ZLO_OUT = 23'd1 << 17;
  localparam word_t C_OUT   = 23'd1 << 18;
  localparam word_t CON_IN  = 23'd1 << 19;
  localparam word_t RUN     = 23'd1 << 22;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ir_out = '0;
  logic        con_ff = 1'b0;
  logic        stop = 1'b0;
  logic gra, grb, grc, rin, rout, baout, pc_out, pc_in, inc_pc, mar_in;
  logic mdr_in, mdr_out, read, write, ir_in, y_in, z_in, zlo_out, c_out, con_in;
  logic [1:0] alu_op;
  logic       run;

  int    vectors = 0;
  int    miscompares = 0;
  exp_t  exp_q[$];
  word_t prog[$];
  word_t actual;

  always #5 clock = ~clock;

  control_sequencer dut (
    .clock(clock), .reset(reset), .ir_out(ir_out), .con_ff(con_ff), .stop(stop),
    .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .baout(baout),
    .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in),
    .mdr_in(mdr_in), .mdr_out(mdr_out), .read(read), .write(write), .ir_in(ir_in),
    .y_in(y_in), .z_in(z_in), .zlo_out(zlo_out), .c_out(c_out), .con_in(con_in),
    .alu_op(alu_op), .run(run)
  );

  assign actual = {run, alu_op, con_in, c_out, zlo_out, z_in, y_in, ir_in, write, read,
                   mdr_out, mdr_in, mar_in, inc_pc, pc_in, pc_out, baout, rout, rin,
                   grc, grb, gra};

  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (actual !== e.w) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.name, actual, e.w);
      end
    end
  end

  function automatic word_t alu(input logic [1:0] a);
    return word_t'(a) << 20;
  endfunction

  // Reference micro-step table per opcode, from T0 through the last execute step.
  task automatic gen_program(input logic [4:0] op, input logic cf);
    logic [1:0] a;
    prog.delete();
    prog.push_back(PC_OUT | MAR_IN | INC_PC | Z_IN | RUN);
    prog.push_back(ZLO_OUT | PC_IN | READ | MDR_IN | RUN);
    prog.push_back(MDR_OUT | IR_IN | RUN);
    case (op)
      5'd4:        a = 2'd1;
      5'd5, 5'd13: a = 2'd2;
      5'd6, 5'd14: a = 2'd3;
      default:     a = 2'd0;
    endcase
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6: begin
        prog.push_back(GRB | ROUT | Y_IN | RUN);
        prog.push_back(GRC | ROUT | alu(a) | Z_IN | RUN);
        prog.push_back(ZLO_OUT | GRA | RIN | RUN);
      end
      5'd12, 5'd13, 5'd14: begin
        prog.push_back(GRB | ROUT | Y_IN | RUN);
        prog.push_back(C_OUT | alu(a) | Z_IN | RUN);
        prog.push_back(ZLO_OUT | GRA | RIN | RUN);
      end
      5'd1: begin
        prog.push_back(GRB | BAOUT | Y_IN | RUN);
        prog.push_back(C_OUT | Z_IN | RUN);
        prog.push_back(ZLO_OUT | GRA | RIN | RUN);
      end
      5'd0: begin
        prog.push_back(GRB | BAOUT | Y_IN | RUN);
        prog.push_back(C_OUT | Z_IN | RUN);
        prog.push_back(ZLO_OUT | MAR_IN | RUN);
        prog.push_back(READ | MDR_IN | RUN);
        prog.push_back(MDR_OUT | GRA | RIN | RUN);
      end
      5'd2: begin
        prog.push_back(GRB | BAOUT | Y_IN | RUN);
        prog.push_back(C_OUT | Z_IN | RUN);
        prog.push_back(ZLO_OUT | MAR_IN | RUN);
        prog.push_back(GRA | ROUT | MDR_IN | RUN);
        prog.push_back(WRITE | RUN);
      end
      5'd18: begin
        prog.push_back(GRA | ROUT | CON_IN | RUN);
        prog.push_back(PC_OUT | Y_IN | RUN);
        prog.push_back(C_OUT | Z_IN | RUN);
        prog.push_back(ZLO_OUT | (cf ? PC_IN : word_t'(0)) | RUN);
      end
      default: ;
    endcase
  endtask

  task automatic cycle(input word_t w, input string name);
    exp_q.push_back('{w, name});
    @(posedge clock);
    #1;
  endtask

  task automatic halt_hold(input int n);
    for (int k = 0; k < n; k++) begin
      ir_out = $urandom;
      stop   = 1'($urandom);
      con_ff = 1'($urandom);
      cycle('0, $sformatf("HALT hold %0d", k));
    end
    reset = 1'b1;
    stop  = 1'b0;
    cycle('0, "HALT at reset");
    reset = 1'b0;
    cycle('0, "RST after halt");
  endtask

  // stop_from: first step index with stop=1 (-1 none); abort_at: step at which reset fires.
  task automatic run_instr(input logic [31:0] ir, input logic cf, input int stop_from,
                           input int abort_at, input int hold_n);
    logic [4:0] op;
    int         last;
    bit         halted;
    op = ir[31:27];
    gen_program(op, cf);
    last = prog.size() - 1;
    for (int i = 0; i <= last; i++) begin
      ir_out = (i < 2) ? $urandom : ir;
      con_ff = (i == 6) ? cf : 1'($urandom);
      stop   = (stop_from >= 0 && i >= stop_from);
      if (i == abort_at) reset = 1'b1;
      cycle(prog[i], $sformatf("ir %h T%0d", ir, i));
      if (i == abort_at) begin
        reset = 1'b0;
        stop  = 1'b0;
        cycle('0, $sformatf("ir %h RST after abort", ir));
        return;
      end
    end
    halted = (op == 5'd27) || (stop_from >= 0 && stop_from <= last);
    stop = 1'b0;
    if (halted) halt_hold(hold_n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] pool [14];
    logic [4:0] op;
    int         sf;
    int         ab;
    pool = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd13, 5'd14,
             5'd18, 5'd26, 5'd27, 5'd0};

    reset = 1'b1;
    @(posedge clock);
    #1;
    cycle('0, "reset cycle 1");
    reset = 1'b0;
    cycle('0, "reset cycle 2");

    run_instr(32'hD8000000, 1'b0, -1, -1, 10);
    run_instr(32'h18918000, 1'b0, -1, -1, 0);
    run_instr(32'h00800055, 1'b0, -1, -1, 0);
    run_instr(32'h91000010, 1'b1, -1, -1, 0);
    run_instr(32'h91000010, 1'b0, -1, -1, 0);
    run_instr(32'h10800020, 1'b0, -1, 6, 0);
    run_instr(32'h18918000, 1'b0, 4, -1, 3);
    run_instr(32'hF8000000, 1'b0, -1, -1, 0);
    run_instr(32'h20918000, 1'b0, -1, -1, 0);

    for (int n = 0; n < 250; n++) begin
      op = ($urandom_range(0, 5) == 0) ? 5'($urandom) : pool[$urandom_range(0, 13)];
      sf = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : -1;
      ab = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 7) : -1;
      run_instr({op, 27'($urandom)}, 1'($urandom), sf, ab, 3);
    end

    @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %0d expected words never compared", exp_q.size());
    end
    if (vectors < 100) begin
      miscompares++;
      $display("FAIL only %0d vectors compared", vectors);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (miscompares != 0) begin
      $display("FAIL: %0d miscompares", miscompares);
    end else begin
      $display("PASS");
    end
    $finish;
  end

endmodule

`default_nettype wire
